// File: rtl/tank_pkg.sv
// tank_pkg: shared constants, types and trig helpers for the tank pose generator.
// Holds screen/format constants, fixed-point and trig types, the FSM state
// enum and a quarter-wave sine table folded out to all 32 headings.
package tank_pkg;
    localparam int ANGLE_W  = 5;
    localparam int TRIG_ONE = 16;
    localparam int FRAC_W   = 4;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic signed [7:0] trig_t;
    typedef logic [13:0] pos_fp_t;
    typedef logic [ANGLE_W-1:0] angle_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROTATE = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_MOVE   = 3'd3,
        ST_CLAMP  = 3'd4,
        ST_COMMIT = 3'd5
    } tank_state_t;

    // round(16*sin(i*11.25 deg)) for i = 0..8
    localparam trig_t QSIN [9] = '{8'sd0, 8'sd3, 8'sd6, 8'sd9, 8'sd11,
                                   8'sd13, 8'sd15, 8'sd16, 8'sd16};

    // Second/fourth quadrants mirror the index, bottom half negates.
    function automatic trig_t trig_sin(angle_t k);
        logic [3:0] idx;
        trig_t mag;
        idx = k[3] ? 4'd8 - {1'b0, k[2:0]} : {1'b0, k[2:0]};
        mag = QSIN[idx];
        return k[4] ? -mag : mag;
    endfunction

    // cos(k) = sin(k + 90 deg), 90 deg being 8 steps
    function automatic trig_t trig_cos(angle_t k);
        return trig_sin(k + angle_t'(8));
    endfunction
endpackage

// File: rtl/tank_motion_trig_rom.sv
// tank_motion_trig_rom: 32-entry synchronous sin/cos ROM, one-cycle read.
// Ports: clk (clock), addr (heading index), sin_val/cos_val (registered
// signed trig values, 1.0 = 16).
module tank_motion_trig_rom
    import tank_pkg::*;
(
    input  logic   clk,
    input  angle_t addr,
    output trig_t  sin_val,
    output trig_t  cos_val
);
    always_ff @(posedge clk) begin
        sin_val <= trig_sin(addr);
        cos_val <= trig_cos(addr);
    end
endmodule

// File: rtl/tank_motion.sv
// tank_motion: once-per-frame tank pose update (rotate, move, clamp, commit).
// Ports: Clk/Reset (async active-low), frame_clk (async vsync strobe),
// key_fwd/key_rev/key_left/key_right (movement keys), TankX/TankY (centre
// pixels), sin_out/cos_out (heading trig, 1.0 = 16), angle (0..31),
// busy (update in flight), upd_done (one-cycle commit pulse).
// Build option: TANK_REVERSE_EN enables reverse motion from key_rev.
module tank_motion
    import tank_pkg::*;
#(
    parameter logic [9:0] START_X   = 10'd320,
    parameter logic [9:0] START_Y   = 10'd240,
    parameter logic [3:0] SPEED     = 4'd1,
    parameter logic [9:0] TANK_SIZE = 10'd8
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   frame_clk,
    input  logic   key_fwd,
    input  logic   key_rev,
    input  logic   key_left,
    input  logic   key_right,
    output logic [9:0] TankX,
    output logic [9:0] TankY,
    output trig_t  sin_out,
    output trig_t  cos_out,
    output angle_t angle,
    output logic   busy,
    output logic   upd_done
);
    localparam logic [9:0] X_HI = 10'(SCREEN_W - 1) - TANK_SIZE;
    localparam logic [9:0] Y_HI = 10'(SCREEN_H - 1) - TANK_SIZE;

    tank_state_t state, state_n;
    logic [2:0] fsync;
    logic frame_tick, fwd_q, left_q, right_q, fwd_mv, rev_mv, ok_x, ok_y;
    angle_t angle_n;
    trig_t sin_r, cos_r;
    pos_fp_t acc_x, acc_y;
    logic signed [14:0] spd, step_x, step_y, dx, dy, cand_x, cand_y;

    // Two sync flops plus one history flop for rising-edge detection
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) fsync <= '0;
        else        fsync <= {fsync[1:0], frame_clk};

    assign frame_tick = fsync[1] & ~fsync[2];
    assign busy       = state != ST_IDLE;

`ifdef TANK_REVERSE_EN
    logic rev_q;
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset)                 rev_q <= 1'b0;
        else if (state == ST_ROTATE) rev_q <= key_rev;
    assign fwd_mv = fwd_q & ~rev_q;
    assign rev_mv = rev_q & ~fwd_q;
`else
    logic unused_rev;
    assign unused_rev = key_rev;
    assign fwd_mv = fwd_q;
    assign rev_mv = 1'b0;
`endif

    tank_motion_trig_rom u_rom (
        .clk     (Clk),
        .addr    (angle_n),
        .sin_val (sin_r),
        .cos_val (cos_r)
    );

    always_comb begin
        angle_n = (left_q & ~right_q) ? angle - angle_t'(1) :
                  (right_q & ~left_q) ? angle + angle_t'(1) : angle;
        spd     = 15'(SPEED);
        step_x  = spd * 15'(cos_r);
        step_y  = spd * 15'(sin_r);
        // Sign bit of the 15-bit candidate flags an underflow past zero
        cand_x  = $signed({1'b0, acc_x}) + dx;
        cand_y  = $signed({1'b0, acc_y}) + dy;
        ok_x    = !cand_x[14] && cand_x[13:FRAC_W] >= TANK_SIZE && cand_x[13:FRAC_W] <= X_HI;
        ok_y    = !cand_y[14] && cand_y[13:FRAC_W] >= TANK_SIZE && cand_y[13:FRAC_W] <= Y_HI;
        state_n = state == ST_IDLE   ? (frame_tick ? ST_ROTATE : ST_IDLE) :
                  state == ST_COMMIT ? ST_IDLE : tank_state_t'(state + 3'd1);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            fwd_q    <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            dx       <= '0;
            dy       <= '0;
            acc_x    <= {START_X, 4'b0};
            acc_y    <= {START_Y, 4'b0};
            TankX    <= START_X;
            TankY    <= START_Y;
            angle    <= '0;
            sin_out  <= 8'sd0;
            cos_out  <= 8'(TRIG_ONE);
            upd_done <= 1'b0;
        end else begin
            state    <= state_n;
            upd_done <= state == ST_COMMIT;
            if (state == ST_ROTATE) begin
                fwd_q   <= key_fwd;
                left_q  <= key_left;
                right_q <= key_right;
            end
            if (state == ST_MOVE) begin
                dx <= fwd_mv ? step_x : rev_mv ? -step_x : '0;
                dy <= fwd_mv ? step_y : rev_mv ? -step_y : '0;
            end
            if (state == ST_CLAMP) begin
                acc_x <= ok_x ? cand_x[13:0] : acc_x;
                acc_y <= ok_y ? cand_y[13:0] : acc_y;
            end
            if (state == ST_COMMIT) begin
                TankX   <= acc_x[13:FRAC_W];
                TankY   <= acc_y[13:FRAC_W];
                angle   <= angle_n;
                sin_out <= sin_r;
                cos_out <= cos_r;
            end
        end
    end
endmodule

// File: tb/tb_tank_motion.sv
// tb_tank_motion: randomized frame stimulus checked every cycle against a pose model.
module tb_tank_motion;
    logic Clk, Reset, frame_clk, key_fwd, key_rev, key_left, key_right;
    logic [9:0] TankX, TankY;
    logic signed [7:0] sin_out, cos_out;
    logic [4:0] angle;
    logic busy, upd_done;

    tank_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .key_fwd(key_fwd), .key_rev(key_rev), .key_left(key_left), .key_right(key_right),
        .TankX(TankX), .TankY(TankY), .sin_out(sin_out), .cos_out(cos_out),
        .angle(angle), .busy(busy), .upd_done(upd_done)
    );

    localparam int TS = 8;
    localparam int SPD = 1;

    int checks = 0, errors = 0, cyc = 0, nupd = 0;
    bit run = 0;
    int m_ax, m_ay, m_ang;
    int v_x, v_y, v_ang, v_sin, v_cos;
    int p_x, p_y, p_ang, p_sin, p_cos;
    int commit_at = -1, busy_lo = -1, busy_hi = -2;

    initial Clk = 0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int tsin(input int k);
        return int'(16.0 * $sin(k * 11.25 * 3.14159265358979 / 180.0));
    endfunction
    function automatic int tcos(input int k);
        return int'(16.0 * $cos(k * 11.25 * 3.14159265358979 / 180.0));
    endfunction

    task automatic model_reset();
        m_ax = 320 * 16; m_ay = 240 * 16; m_ang = 0;
        v_x = 320; v_y = 240; v_ang = 0; v_sin = 0; v_cos = 16;
        commit_at = -1; busy_lo = -1; busy_hi = -2;
    endtask

    // One frame: turn, then step along the new heading; each axis that would
    // leave [TS, last-TS] keeps its old position.
    task automatic model_frame(input bit f, input bit v, input bit l, input bit r, input int n);
        int dir, nx, ny;
        if (l && !r) m_ang = (m_ang + 31) % 32;
        else if (r && !l) m_ang = (m_ang + 1) % 32;
`ifdef TANK_REVERSE_EN
        dir = (f && !v) ? 1 : (v && !f) ? -1 : 0;
`else
        dir = f ? 1 : 0;
`endif
        nx = m_ax + dir * SPD * tcos(m_ang);
        ny = m_ay + dir * SPD * tsin(m_ang);
        if (nx >= TS * 16 && nx < (640 - TS) * 16) m_ax = nx;
        if (ny >= TS * 16 && ny < (480 - TS) * 16) m_ay = ny;
        p_x = m_ax / 16; p_y = m_ay / 16; p_ang = m_ang;
        p_sin = tsin(m_ang); p_cos = tcos(m_ang);
        commit_at = n + 8; busy_lo = n + 3; busy_hi = n + 7;
    endtask

    always @(negedge Clk) begin
        if (run && Reset) begin
            if (cyc == commit_at) begin
                v_x = p_x; v_y = p_y; v_ang = p_ang; v_sin = p_sin; v_cos = p_cos;
            end
            if (upd_done) nupd++;
            chk("TankX", int'(TankX), v_x);
            chk("TankY", int'(TankY), v_y);
            chk("angle", int'(angle), v_ang);
            chk("sin_out", int'(sin_out), v_sin);
            chk("cos_out", int'(cos_out), v_cos);
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            chk("upd_done", int'(upd_done), int'(cyc == commit_at));
        end
    end

    task automatic check_reset_vals();
        chk("rst_TankX", int'(TankX), 320);
        chk("rst_TankY", int'(TankY), 240);
        chk("rst_angle", int'(angle), 0);
        chk("rst_sin", int'(sin_out), 0);
        chk("rst_cos", int'(cos_out), 16);
        chk("rst_busy", int'(busy), 0);
        chk("rst_upd", int'(upd_done), 0);
    endtask

    task automatic reset_dut();
        @(posedge Clk); #1;
        Reset = 0;
        model_reset();
        #1 check_reset_vals();
        repeat (2) @(posedge Clk);
        #1 Reset = 1;
        repeat (2) @(posedge Clk);
    endtask

    // mode 0: single edge; 1: second edge while busy; 2: reset during MOVE
    task automatic frame(input bit f, input bit v, input bit l, input bit r, input int mode);
        int n, u0;
        @(posedge Clk); #1;
        n = cyc; u0 = nupd;
        key_fwd = f; key_rev = v; key_left = l; key_right = r;
        frame_clk = 1;
        model_frame(f, v, l, r, n);
        repeat (3) @(posedge Clk);
        #1 frame_clk = 0;
        if (mode == 1) begin
            @(posedge Clk); #1 frame_clk = 1;
            repeat (3) @(posedge Clk);
            #1 frame_clk = 0;
        end
        if (mode == 2) begin
            repeat (2) @(posedge Clk);
            #3 Reset = 0;
            model_reset();
            #1 check_reset_vals();
            repeat (3) @(posedge Clk);
            #1 Reset = 1;
        end
        repeat (10) @(posedge Clk);
        chk("upd_pulses", nupd - u0, mode == 2 ? 0 : 1);
    endtask

    initial begin
        Reset = 0; frame_clk = 0;
        key_fwd = 0; key_rev = 0; key_left = 0; key_right = 0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1 check_reset_vals();
        Reset = 1;
        @(negedge Clk);
        check_reset_vals();
        run = 1;

        frame(1, 0, 0, 0, 0);
        chk("fwd_x", int'(TankX), 321);
        chk("fwd_y", int'(TankY), 240);

        reset_dut();
        repeat (8) frame(0, 0, 0, 1, 0);
        frame(1, 0, 0, 0, 0);
        chk("a8_angle", int'(angle), 8);
        chk("a8_sin", int'(sin_out), 16);
        chk("a8_cos", int'(cos_out), 0);
        chk("a8_y", int'(TankY), 241);
        chk("a8_x", int'(TankX), 320);

        reset_dut();
        frame(0, 0, 1, 0, 0);
        chk("wrap_dn", int'(angle), 31);
        frame(0, 0, 0, 1, 0);
        chk("wrap_up", int'(angle), 0);
        frame(0, 0, 1, 1, 0);
        chk("both_lr", int'(angle), 0);

        reset_dut();
        repeat (311) frame(1, 0, 0, 0, 0);
        chk("wall_reach", int'(TankX), 631);
        frame(1, 0, 0, 0, 0);
        chk("wall_x", int'(TankX), 631);
        chk("wall_y", int'(TankY), 240);

        frame(0, 0, 0, 1, 1);
        frame(1, 0, 0, 0, 2);

        reset_dut();
        frame(0, 1, 0, 0, 0);
`ifdef TANK_REVERSE_EN
        chk("rev_x", int'(TankX), 319);
`else
        chk("rev_x", int'(TankX), 320);
`endif

        for (int i = 0; i < 300; i++) begin
            int mode;
            mode = ($urandom_range(0, 19) == 0) ? 1 : 0;
            frame($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, mode);
        end
        frame(1, 0, 0, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
